// File: rtl/neuron_controller.sv
// Start/done sequencer for the single-neuron MAC datapath (memories, x/w registers,
// accumulator, activation, result register). Define NEURON_CTRL_ABORT_EN to add an abort input.
module neuron_controller #(
   parameter int Q   = 4,
   parameter int d   = 4,
   parameter int DIM = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
`ifdef NEURON_CTRL_ABORT_EN
   input  logic         abort,
`endif
   input  logic [Q-1:0] row_x,
   input  logic [Q-1:0] row_w,
   output logic         busy,
   output logic         done,
   output logic         clear_acc,
   output logic         memRead_x,
   output logic         memRead_w,
   output logic [Q-1:0] addr_x,
   output logic [Q-1:0] addr_w,
   output logic [d-1:0] index_d_x,
   output logic [d-1:0] index_d_w,
   output logic         x_write,
   output logic         w_write,
   output logic         acc_en,
   output logic         ready,
   output logic         res_write
);

   typedef enum logic [2:0] {
      IDLE, CLEAR, READ, LOAD, MAC, ACT, STORE, DONE
   } state_t;

   // When DIM == 2**d this equals all-ones, so the exit test and the natural wrap coincide.
   localparam logic [d-1:0] LAST_IDX = d'(DIM - 1);

   state_t         state_q, state_d;
   logic [d-1:0]   idx_q, idx_d;
   logic [Q-1:0]   addr_x_q, addr_x_d;
   logic [Q-1:0]   addr_w_q, addr_w_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         addr_x_q <= '0;
         addr_w_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         addr_x_q <= addr_x_d;
         addr_w_q <= addr_w_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      addr_x_d = addr_x_q;
      addr_w_d = addr_w_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = CLEAR;
               idx_d    = '0;
               addr_x_d = row_x;
               addr_w_d = row_w;
            end
         end
         CLEAR: state_d = READ;
         READ:  state_d = LOAD;
         LOAD:  state_d = MAC;
         MAC: begin
            if (idx_q == LAST_IDX) begin
               idx_d   = '0;
               state_d = ACT;
            end else begin
               idx_d   = idx_q + d'(1);
               state_d = READ;
            end
         end
         ACT:   state_d = STORE;
         STORE: state_d = DONE;
         DONE:  state_d = IDLE;
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
`ifdef NEURON_CTRL_ABORT_EN
      // Abort overrides every transition except the IDLE wait and the final done pulse.
      if (abort && (state_q != IDLE) && (state_q != DONE)) begin
         state_d = IDLE;
         idx_d   = '0;
      end
`endif
   end

   // Moore decode: strobes depend on the state register only.
   always_comb begin
      clear_acc = 1'b0;
      memRead_x = 1'b0;
      memRead_w = 1'b0;
      x_write   = 1'b0;
      w_write   = 1'b0;
      acc_en    = 1'b0;
      ready     = 1'b0;
      res_write = 1'b0;
      done      = 1'b0;
      unique case (state_q)
         CLEAR: clear_acc = 1'b1;
         READ: begin
            memRead_x = 1'b1;
            memRead_w = 1'b1;
         end
         LOAD: begin
            x_write = 1'b1;
            w_write = 1'b1;
         end
         MAC:   acc_en = 1'b1;
         ACT:   ready  = 1'b1;
         STORE: begin
            ready     = 1'b1;
            res_write = 1'b1;
         end
         DONE:  done = 1'b1;
         default: ;
      endcase
   end

   assign busy      = (state_q != IDLE);
   assign addr_x    = addr_x_q;
   assign addr_w    = addr_w_q;
   assign index_d_x = idx_q;
   assign index_d_w = idx_q;

endmodule
